// File: rtl/reg_file_sb_if.sv
// Register file bus: read ports, write-back port, reserve port.
// Master drives requests; slave (the register file) returns data/status.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              rd_en;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rs_busy;
    logic              rt_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_err;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output rd_en, rs_addr, rt_addr,
        output wr_en, wr_addr, wr_data,
        output rsv_en, rsv_addr,
        input  rs_data, rt_data, rs_busy, rt_busy,
        input  rsv_err, busy_cnt
    );

    modport slave (
        input  rd_en, rs_addr, rt_addr,
        input  wr_en, wr_addr, wr_data,
        input  rsv_en, rsv_addr,
        output rs_data, rt_data, rs_busy, rt_busy,
        output rsv_err, busy_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard and write-back bypass.
// Two registered read ports, one write-back port, one reserve port.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         rst,
    reg_file_sb_if.slave bus
);
    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic              wr_ok;
    logic              rsv_ok;
    logic              err_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] rs_nxt;
    logic [DATA_W-1:0] rt_nxt;

    logic [DATA_W-1:0] rs_q;
    logic [DATA_W-1:0] rt_q;
    logic              rs_b_q;
    logic              rt_b_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Value a read of address a sees after this edge's write.
    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
        if (is_zero(a))
            return '0;
        if ((BYPASS != 0) && wr_ok && (bus.wr_addr == a))
            return bus.wr_data;
        return mem[a];
    endfunction

    // Qualify strobes; register 0 swallows writes and reserves.
    always_comb begin
        wr_ok  = bus.wr_en && !is_zero(bus.wr_addr);
        rsv_ok = bus.rsv_en && !is_zero(bus.rsv_addr);
    end

    // Next busy vector: write clears, then reserve sets (reserve wins).
    // A same-address write retires the old producer, so no error then.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[bus.wr_addr] = 1'b0;
        if (rsv_ok)
            busy_nxt[bus.rsv_addr] = 1'b1;
        err_nxt = rsv_ok && busy[bus.rsv_addr]
                  && !(wr_ok && (bus.wr_addr == bus.rsv_addr));
    end

    // Popcount of next-state busy vector; CNT_W bits cannot wrap.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
    end

    // Read data candidates for both ports.
    always_comb begin
        rs_nxt = rd_val(bus.rs_addr);
        rt_nxt = rd_val(bus.rt_addr);
    end

    // Storage array and busy bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                mem[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok)
                mem[bus.wr_addr] <= bus.wr_data;
            busy <= busy_nxt;
        end
    end

    // Registered outputs; read ports hold when rd_en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q   <= '0;
            rt_q   <= '0;
            rs_b_q <= 1'b0;
            rt_b_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (bus.rd_en) begin
                rs_q   <= rs_nxt;
                rt_q   <= rt_nxt;
                rs_b_q <= busy_nxt[bus.rs_addr] && !is_zero(bus.rs_addr);
                rt_b_q <= busy_nxt[bus.rt_addr] && !is_zero(bus.rt_addr);
            end
            err_q <= err_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    assign bus.rs_data  = rs_q;
    assign bus.rt_data  = rt_q;
    assign bus.rs_busy  = rs_b_q;
    assign bus.rt_busy  = rt_b_q;
    assign bus.rsv_err  = err_q;
    assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vectors, expectations queued per cycle,
// a monitor pops and compares after each rising edge.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file_sb #(
        .DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          id;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic        rsb;
        logic        rtb;
        logic        err;
        logic [5:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec   = 0;

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %h want %h", nm, id, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(
        input logic r, input logic rd, input logic [4:0] rs, input logic [4:0] rt,
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic re, input logic [4:0] ra,
        input logic [31:0] ersd, input logic [31:0] ertd,
        input logic ersb, input logic ertb, input logic eerr, input logic [5:0] ecnt);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.rd_en    = rd;
        bus.rs_addr  = rs;
        bus.rt_addr  = rt;
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rsv_en   = re;
        bus.rsv_addr = ra;
        vec++;
        e.id  = vec;
        e.rsd = ersd;
        e.rtd = ertd;
        e.rsb = ersb;
        e.rtb = ertb;
        e.err = eerr;
        e.cnt = ecnt;
        q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, one edge after the stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rs_data", e.id, bus.rs_data, e.rsd);
                chk("rt_data", e.id, bus.rt_data, e.rtd);
                chk("rs_busy", e.id, 32'(bus.rs_busy), 32'(e.rsb));
                chk("rt_busy", e.id, 32'(bus.rt_busy), 32'(e.rtb));
                chk("rsv_err", e.id, 32'(bus.rsv_err), 32'(e.err));
                chk("busy_cnt", e.id, 32'(bus.busy_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        bus.rd_en = 0; bus.rs_addr = 0; bus.rt_addr = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.rsv_en = 0; bus.rsv_addr = 0;

        // reset with writes/reserves active, then read r5
        step(1,1,3,5, 1,3,32'hAAAA_AAAA, 1,5, 0,0,0,0,0,0);
        step(1,1,3,5, 1,3,32'hBBBB_BBBB, 1,5, 0,0,0,0,0,0);
        step(0,1,5,0, 0,0,0, 0,0,            0,0,0,0,0,0);
        // write r3 then read it, then hold
        step(0,0,0,0, 1,3,32'hDEAD_BEEF, 0,0, 0,0,0,0,0,0);
        step(0,1,3,3, 0,0,0, 0,0,  32'hDEAD_BEEF,32'hDEAD_BEEF,0,0,0,0);
        step(0,0,7,7, 0,0,0, 0,0,  32'hDEAD_BEEF,32'hDEAD_BEEF,0,0,0,0);
        // bypass: write r7 and read r7 on both ports same cycle
        step(0,1,7,7, 1,7,32'h1234, 0,0, 32'h1234,32'h1234,0,0,0,0);
        step(0,1,7,3, 0,0,0, 0,0,  32'h1234,32'hDEAD_BEEF,0,0,0,0);
        // zero register: write and reserve r0
        step(0,1,0,0, 1,0,32'hFFFF_FFFF, 1,0, 0,0,0,0,0,0);
        step(0,1,0,7, 0,0,0, 0,0,  0,32'h1234,0,0,0,0);
        // scoreboard on r4
        step(0,1,4,7, 0,0,0, 1,4,  0,32'h1234,1,0,0,1);
        step(0,0,0,0, 0,0,0, 1,4,  0,32'h1234,1,0,1,1);
        step(0,0,0,0, 0,0,0, 0,0,  0,32'h1234,1,0,0,1);
        step(0,1,4,4, 1,4,32'h44, 0,0, 32'h44,32'h44,0,0,0,0);
        // write+reserve same register while busy
        step(0,0,0,0, 0,0,0, 1,9,  32'h44,32'h44,0,0,0,1);
        step(0,1,9,4, 1,9,32'h99, 1,9, 32'h99,32'h44,1,0,0,1);
        step(0,1,9,9, 0,0,0, 0,0,  32'h99,32'h99,1,1,0,1);
        // reserve r1..r6 on top of r9
        for (int i = 1; i <= 6; i++)
            step(0,0,0,0, 0,0,0, 1,5'(i), 32'h99,32'h99,1,1,0,6'(i+1));
        // reset during a write to r2, then read r2/r1
        step(1,1,2,9, 1,2,32'h22, 0,0, 0,0,0,0,0,0);
        step(0,1,2,1, 0,0,0, 0,0,  0,0,0,0,0,0);
        step(0,0,0,0, 0,0,0, 0,0,  0,0,0,0,0,0);

        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
